// File: rtl/cache_way_select_pipe_if.sv
// Stream bundle for cache_way_select_pipe.
//   master : upstream tag-compare + downstream consumer side (drives in_*, out_ready)
//   slave  : the way-select pipe (drives in_ready, out_*)
// in_lines packs way w at bits [w*LINE_W +: LINE_W].
interface cache_way_select_pipe_if #(
  parameter int unsigned WAYS   = 8,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned WORD_W = 32
);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned OFF_W = (LINE_W / WORD_W > 1) ? $clog2(LINE_W / WORD_W) : 1;

  logic                     in_valid;
  logic                     in_ready;
  logic [WAYS*LINE_W-1:0]   in_lines;
  logic [WAYS-1:0]          in_hit;
  logic [OFF_W-1:0]         in_word_off;
  logic                     out_valid;
  logic                     out_ready;
  logic [LINE_W-1:0]        out_line;
  logic [WORD_W-1:0]        out_word;
  logic [WAY_W-1:0]         out_way;
  logic                     out_hit;
  logic                     out_multi_hit;

  modport master (
    output in_valid, in_lines, in_hit, in_word_off, out_ready,
    input  in_ready, out_valid, out_line, out_word, out_way, out_hit, out_multi_hit
  );

  modport slave (
    input  in_valid, in_lines, in_hit, in_word_off, out_ready,
    output in_ready, out_valid, out_line, out_word, out_way, out_hit, out_multi_hit
  );
endinterface

// File: rtl/cache_way_select_pipe.sv
// Two-stage pipelined way select for the cache read path.
// S1 priority-encodes the hit vector (lowest way wins), flags hit/multi-hit and keeps only the
// selected line; S2 extracts the addressed word. All out_* come straight from S2 flops.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   flush      : sync drop of all in-flight entries; blocks input while high
//   bus        : slave side of cache_way_select_pipe_if (request in, response out, valid/ready)
module cache_way_select_pipe #(
  parameter int unsigned WAYS   = 8,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned WORD_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  cache_way_select_pipe_if.slave bus
);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned WORDS = LINE_W / WORD_W;
  localparam int unsigned OFF_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  // Stage S1 state
  logic              s1_valid_q;
  logic [WAY_W-1:0]  s1_way_q;
  logic              s1_hit_q;
  logic              s1_multi_q;
  logic [LINE_W-1:0] s1_line_q;
  logic [OFF_W-1:0]  s1_off_q;

  // Stage S2 state
  logic              s2_valid_q;
  logic [WAY_W-1:0]  s2_way_q;
  logic              s2_hit_q;
  logic              s2_multi_q;
  logic [LINE_W-1:0] s2_line_q;
  logic [WORD_W-1:0] s2_word_q;

  logic              adv1, adv2;
  logic [WAY_W-1:0]  sel_way;
  logic [LINE_W-1:0] sel_line;
  logic              any_hit, multi_hit;
  logic [OFF_W-1:0]  eff_off;
  logic [WORD_W-1:0] s1_word;

  assign adv2         = !s2_valid_q || bus.out_ready;
  assign adv1         = !s1_valid_q || adv2;
  assign bus.in_ready = adv1 && !flush;

  // Scan from the top down so the last match, i.e. the lowest set way, wins.
  // A miss leaves the line and way at zero.
  always_comb begin
    sel_way  = '0;
    sel_line = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (bus.in_hit[w]) begin
        sel_way  = WAY_W'(w);
        sel_line = bus.in_lines[w*LINE_W +: LINE_W];
      end
    end
  end

  assign any_hit   = |bus.in_hit;
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign multi_hit = |(bus.in_hit & (bus.in_hit - WAYS'(1)));

  // A single-word line has only offset 0.
  assign eff_off = (WORDS > 1) ? s1_off_q : '0;

  always_comb begin
    s1_word = s1_line_q[eff_off*WORD_W +: WORD_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_way_q   <= '0;
      s1_hit_q   <= 1'b0;
      s1_multi_q <= 1'b0;
      s1_line_q  <= '0;
      s1_off_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_way_q   <= '0;
      s2_hit_q   <= 1'b0;
      s2_multi_q <= 1'b0;
      s2_line_q  <= '0;
      s2_word_q  <= '0;
    end else if (flush) begin
      // Flush wins over any handshake this cycle; data flops keep stale but invalid contents.
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_way_q   <= sel_way;
          s1_hit_q   <= any_hit;
          s1_multi_q <= multi_hit;
          s1_line_q  <= sel_line;
          s1_off_q   <= bus.in_word_off;
        end
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_way_q   <= s1_way_q;
          s2_hit_q   <= s1_hit_q;
          s2_multi_q <= s1_multi_q;
          s2_line_q  <= s1_line_q;
          s2_word_q  <= s1_word;
        end
      end
    end
  end

  assign bus.out_valid     = s2_valid_q;
  assign bus.out_line      = s2_line_q;
  assign bus.out_word      = s2_word_q;
  assign bus.out_way       = s2_way_q;
  assign bus.out_hit       = s2_hit_q;
  assign bus.out_multi_hit = s2_multi_q;
endmodule

// File: tb/tb_cache_way_select_pipe.sv
// Directed + random bench for cache_way_select_pipe: default config (A) and
// WAYS=4/LINE_W=512/WORD_W=64 (B), each checked against a scoreboard of model results.
module tb_cache_way_select_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush_a = 1'b0;
  logic flush_b = 1'b0;

  always #5 clk = ~clk;

  cache_way_select_pipe_if #(.WAYS(8), .LINE_W(256), .WORD_W(32)) ifa ();
  cache_way_select_pipe_if #(.WAYS(4), .LINE_W(512), .WORD_W(64)) ifb ();

  cache_way_select_pipe #(.WAYS(8), .LINE_W(256), .WORD_W(32)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_a),
    .bus   (ifa)
  );

  cache_way_select_pipe #(.WAYS(4), .LINE_W(512), .WORD_W(64)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_b),
    .bus   (ifb)
  );

  typedef struct packed {
    logic [511:0] line;
    logic [63:0]  word;
    logic [2:0]   way;
    logic         hit;
    logic         multi;
  } exp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rx_a = 0;
  int rx_b = 0;
  int rx_cyc_a[$];
  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t ea, eb;

  task automatic chk(string tag, logic [1023:0] obs, logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first set hit bit from way 0 upward; line/word shifted out of the packed vector.
  function automatic exp_t model(int ways, int lw, int ww, logic [2047:0] lines,
                                 logic [7:0] hit, int off);
    exp_t e = '0;
    logic [511:0] lmask, wmask;
    lmask = '1;
    lmask = lmask >> (512 - lw);
    wmask = '1;
    wmask = wmask >> (512 - ww);
    e.hit   = (hit != 8'd0);
    e.multi = ($countones(hit) > 1);
    for (int w = 0; w < ways; w++) begin
      if (hit[w]) begin
        e.way  = 3'(w);
        e.line = 512'(lines >> (w * lw)) & lmask;
        break;
      end
    end
    e.word = 64'((e.line >> (off * ww)) & wmask);
    return e;
  endfunction

  function automatic logic [2047:0] idx_lines(int ways, int lw);
    logic [2047:0] v = '0;
    for (int w = 0; w < ways; w++)
      for (int b = 0; b < lw; b += 32) v[w*lw + b +: 32] = 32'(w);
    return v;
  endfunction

  function automatic logic [2047:0] rnd_lines();
    logic [2047:0] v;
    for (int i = 0; i < 64; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Handshakes are judged at the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n || flush_a) begin
      sb_a.delete();
    end else begin
      if (ifa.out_valid && ifa.out_ready) begin
        chk("a_resp_expected", 1024'(sb_a.size() != 0), 1024'(1));
        if (sb_a.size() != 0) begin
          ea = sb_a.pop_front();
          chk("a_line", 1024'(ifa.out_line), 1024'(ea.line));
          chk("a_word", 1024'(ifa.out_word), 1024'(ea.word));
          chk("a_way", 1024'(ifa.out_way), 1024'(ea.way));
          chk("a_hit", 1024'(ifa.out_hit), 1024'(ea.hit));
          chk("a_multi", 1024'(ifa.out_multi_hit), 1024'(ea.multi));
        end
        rx_a++;
        rx_cyc_a.push_back(cyc);
      end
      if (ifa.in_valid && ifa.in_ready)
        sb_a.push_back(model(8, 256, 32, ifa.in_lines, ifa.in_hit, int'(ifa.in_word_off)));
    end
    if (!rst_n || flush_b) begin
      sb_b.delete();
    end else begin
      if (ifb.out_valid && ifb.out_ready) begin
        chk("b_resp_expected", 1024'(sb_b.size() != 0), 1024'(1));
        if (sb_b.size() != 0) begin
          eb = sb_b.pop_front();
          chk("b_line", 1024'(ifb.out_line), 1024'(eb.line));
          chk("b_word", 1024'(ifb.out_word), 1024'(eb.word));
          chk("b_way", 1024'(ifb.out_way), 1024'(eb.way));
          chk("b_hit", 1024'(ifb.out_hit), 1024'(eb.hit));
          chk("b_multi", 1024'(ifb.out_multi_hit), 1024'(eb.multi));
        end
        rx_b++;
      end
      if (ifb.in_valid && ifb.in_ready)
        sb_b.push_back(model(4, 512, 64, ifb.in_lines, {4'b0, ifb.in_hit},
                             int'(ifb.in_word_off)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(logic [2047:0] lines, logic [7:0] hit, logic [2:0] off);
    bit acc = 1'b0;
    ifa.in_lines    = lines;
    ifa.in_hit      = hit;
    ifa.in_word_off = off;
    ifa.in_valid    = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = ifa.in_ready;
      tick();
    end
    chk("a_send_accepted", 1024'(acc), 1024'(1));
    ifa.in_valid = 1'b0;
  endtask

  task automatic rand_req_a();
    ifa.in_lines    = rnd_lines();
    ifa.in_hit      = 8'($urandom());
    ifa.in_word_off = 3'($urandom());
  endtask

  // Hold in_valid high for a number of cycles, moving to new data after each acceptance.
  task automatic stream_a(int cycles, output int accepted);
    bit acc;
    accepted = 0;
    ifa.in_valid = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      acc = ifa.in_ready;
      tick();
      if (acc) begin
        accepted++;
        rand_req_a();
      end
    end
  endtask

  task automatic rand_req_b();
    int mode;
    ifb.in_lines    = rnd_lines();
    ifb.in_word_off = 3'($urandom());
    mode = int'($urandom_range(0, 3));
    if (mode == 0) ifb.in_hit = 4'b0000;
    else if (mode == 1) ifb.in_hit = 4'(1 << $urandom_range(0, 3));
    else ifb.in_hit = 4'($urandom());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n, acc2, rx0, last;
    logic [255:0] snap_line;
    logic [31:0]  snap_word;
    logic [2:0]   snap_way;
    bit           acc;

    ifa.in_valid = 1'b0; ifa.in_lines = '0; ifa.in_hit = '0; ifa.in_word_off = '0;
    ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_lines = '0; ifb.in_hit = '0; ifb.in_word_off = '0;
    ifb.out_ready = 1'b0;

    // Reset
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 1024'(ifa.out_valid), 1024'(0));
    chk("rst_out_line", 1024'(ifa.out_line), 1024'(0));
    chk("rst_out_way", 1024'(ifa.out_way), 1024'(0));
    chk("rst_out_hit", 1024'(ifa.out_hit), 1024'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 1024'(ifa.in_ready), 1024'(1));

    // 1. Single hit, 2-cycle latency
    ifa.out_ready = 1'b1;
    send_a(idx_lines(8, 256), 8'b0000_0100, 3'd3);
    chk("t1_valid_after_1", 1024'(ifa.out_valid), 1024'(0));
    tick();
    chk("t1_valid_after_2", 1024'(ifa.out_valid), 1024'(1));
    chk("t1_way", 1024'(ifa.out_way), 1024'(2));
    chk("t1_word", 1024'(ifa.out_word), 1024'(32'h2));
    chk("t1_hit", 1024'(ifa.out_hit), 1024'(1));
    chk("t1_multi", 1024'(ifa.out_multi_hit), 1024'(0));

    // 2. Miss, then multi-hit
    send_a(idx_lines(8, 256), 8'b0000_0000, 3'd5);
    tick();
    chk("t2_miss_valid", 1024'(ifa.out_valid), 1024'(1));
    chk("t2_miss_hit", 1024'(ifa.out_hit), 1024'(0));
    chk("t2_miss_line", 1024'(ifa.out_line), 1024'(0));
    chk("t2_miss_way", 1024'(ifa.out_way), 1024'(0));
    send_a(idx_lines(8, 256), 8'b1010_0000, 3'd1);
    tick();
    chk("t2_multi_way", 1024'(ifa.out_way), 1024'(5));
    chk("t2_multi_flag", 1024'(ifa.out_multi_hit), 1024'(1));
    chk("t2_multi_hit", 1024'(ifa.out_hit), 1024'(1));
    chk("t2_multi_word", 1024'(ifa.out_word), 1024'(32'h5));
    tick();

    // 3. Streaming 16 back-to-back
    rx0 = rx_a;
    rand_req_a();
    ifa.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("t3_in_ready", 1024'(ifa.in_ready), 1024'(1));
      tick();
      rand_req_a();
    end
    ifa.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t3_count", 1024'(rx_a - rx0), 1024'(16));
    last = rx_cyc_a.size() - 1;
    chk("t3_consecutive", 1024'(rx_cyc_a[last] - rx_cyc_a[last-15]), 1024'(15));

    // 4. Backpressure
    rx0 = rx_a;
    ifa.out_ready = 1'b0;
    rand_req_a();
    stream_a(5, acc_n);
    chk("t4_buffered", 1024'(sb_a.size()), 1024'(2));
    chk("t4_accepted", 1024'(acc_n), 1024'(2));
    chk("t4_in_ready", 1024'(ifa.in_ready), 1024'(0));
    chk("t4_out_valid", 1024'(ifa.out_valid), 1024'(1));
    snap_line = ifa.out_line; snap_word = ifa.out_word; snap_way = ifa.out_way;
    tick(); tick();
    chk("t4_stable_line", 1024'(ifa.out_line), 1024'(snap_line));
    chk("t4_stable_word", 1024'(ifa.out_word), 1024'(snap_word));
    chk("t4_stable_way", 1024'(ifa.out_way), 1024'(snap_way));
    ifa.out_ready = 1'b1;
    stream_a(4, acc2);
    ifa.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("t4_drained", 1024'(sb_a.size()), 1024'(0));
    chk("t4_no_loss_dup", 1024'(rx_a - rx0), 1024'(acc_n + acc2));

    // 5a. Flush with 2 in flight
    ifa.out_ready = 1'b0;
    rand_req_a();
    stream_a(3, acc_n);
    chk("t5_inflight", 1024'(sb_a.size()), 1024'(2));
    flush_a = 1'b1;
    #1;
    chk("t5_flush_in_ready", 1024'(ifa.in_ready), 1024'(0));
    tick();
    flush_a = 1'b0;
    ifa.in_valid = 1'b0;
    chk("t5_flush_out_valid", 1024'(ifa.out_valid), 1024'(0));
    rx0 = rx_a;
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_flushed_gone", 1024'(rx_a - rx0), 1024'(0));

    // 5b. Async reset mid-stream
    rand_req_a();
    stream_a(3, acc_n);
    #2 rst_n = 1'b0;
    #1;
    ifa.in_valid = 1'b0;
    chk("t5_rst_out_valid", 1024'(ifa.out_valid), 1024'(0));
    chk("t5_rst_out_line", 1024'(ifa.out_line), 1024'(0));
    chk("t5_rst_out_word", 1024'(ifa.out_word), 1024'(0));
    chk("t5_rst_out_hit", 1024'(ifa.out_hit), 1024'(0));
    tick();
    rst_n = 1'b1;
    rx0 = rx_a;
    tick();
    chk("t5_rst_in_ready", 1024'(ifa.in_ready), 1024'(1));
    for (int i = 0; i < 4; i++) tick();
    chk("t5_rst_no_partial", 1024'(rx_a - rx0), 1024'(0));

    // 6. WAYS=4, LINE_W=512, WORD_W=64 random against the model
    acc_n = 0;
    rand_req_b();
    ifb.in_valid = 1'b1;
    for (int g = 0; g < 20000 && acc_n < 1000; g++) begin
      ifb.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = ifb.in_ready;
      tick();
      if (acc) begin
        acc_n++;
        rand_req_b();
      end
    end
    ifb.in_valid = 1'b0;
    ifb.out_ready = 1'b1;
    for (int i = 0; i < 20 && sb_b.size() != 0; i++) tick();
    chk("t6_drained", 1024'(sb_b.size()), 1024'(0));
    chk("t6_count", 1024'(rx_b), 1024'(1000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
